// File: rtl/ddr_line_server.sv
// Responder for cache-line bursts: write-back (cache -> memory) and fill (memory -> cache) over a 16-bit memory.
// Define LINESRV_STATS_EN to add saturating wb_count/fill_count burst counters.
module ddr_line_server #(
  parameter int ADDR   = 21,
  parameter int LINE   = 6,
  parameter int RD_LAT = 2
) (
  input  logic                 ddr_clk,
  input  logic                 rst,
  input  logic                 ddr_rd,
  input  logic                 ddr_wr,
  input  logic [ADDR-LINE-1:0] hiaddr,
  input  logic [15:0]          ddr_dout,
  output logic [15:0]          ddr_din,
  output logic                 cache_read_data,
  output logic                 cache_write_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR-2:0]      mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_ack,
`ifdef LINESRV_STATS_EN
  output logic [15:0]          wb_count,
  output logic [15:0]          fill_count,
`endif
  output logic                 busy
);

  localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LCW-1:0]  LC_INIT = LCW'(RD_LAT - 1);
  localparam logic [LINE-2:0] WC_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, WB_STB, WB_WAIT, WB_MEM, FL_MEM, FL_STB, DONE
  } state_t;

  state_t                state, next_state;
  logic [ADDR-LINE-1:0]  line;
  logic [LINE-2:0]       wc;
  logic [LCW-1:0]        lc;

  logic latch_line, wc_clr, wc_inc, lc_load, lc_dec;
  logic cap_wdata, cap_rdata, wb_done, fill_done;

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Strobes and mem_req decode straight from state so a reset drops them without a clock.
  always_comb begin
    next_state       = state;
    latch_line       = 1'b0;
    wc_clr           = 1'b0;
    wc_inc           = 1'b0;
    lc_load          = 1'b0;
    lc_dec           = 1'b0;
    cap_wdata        = 1'b0;
    cap_rdata        = 1'b0;
    wb_done          = 1'b0;
    fill_done        = 1'b0;
    cache_read_data  = 1'b0;
    cache_write_data = 1'b0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    case (state)
      IDLE: begin
        if (ddr_wr) begin
          latch_line = 1'b1;
          wc_clr     = 1'b1;
          next_state = WB_STB;
        end else if (ddr_rd) begin
          latch_line = 1'b1;
          wc_clr     = 1'b1;
          next_state = FL_MEM;
        end
      end
      WB_STB: begin
        cache_read_data = 1'b1;
        lc_load         = 1'b1;
        next_state      = WB_WAIT;
      end
      WB_WAIT: begin
        if (lc == '0) begin
          cap_wdata  = 1'b1;
          next_state = WB_MEM;
        end else begin
          lc_dec = 1'b1;
        end
      end
      WB_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          if (wc == WC_LAST) begin
            wc_clr  = 1'b1;
            wb_done = 1'b1;
            if (ddr_rd) begin
              latch_line = 1'b1;
              next_state = FL_MEM;
            end else begin
              next_state = IDLE;
            end
          end else begin
            wc_inc     = 1'b1;
            next_state = WB_STB;
          end
        end
      end
      FL_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          cap_rdata  = 1'b1;
          next_state = FL_STB;
        end
      end
      FL_STB: begin
        cache_write_data = 1'b1;
        if (wc == WC_LAST) begin
          wc_clr     = 1'b1;
          fill_done  = 1'b1;
          next_state = DONE;
        end else begin
          wc_inc     = 1'b1;
          next_state = FL_MEM;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      line      <= '0;
      wc        <= '0;
      lc        <= '0;
      mem_wdata <= '0;
      ddr_din   <= '0;
    end else begin
      if (latch_line) line <= hiaddr;
      if (wc_clr)      wc <= '0;
      else if (wc_inc) wc <= wc + 1'b1;
      if (lc_load)     lc <= LC_INIT;
      else if (lc_dec) lc <= lc - 1'b1;
      if (cap_wdata)   mem_wdata <= ddr_dout;
      if (cap_rdata)   ddr_din   <= mem_rdata;
    end
  end

  assign mem_addr = {line, wc};
  assign busy     = (state != IDLE);

`ifdef LINESRV_STATS_EN
  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      wb_count   <= '0;
      fill_count <= '0;
    end else begin
      if (wb_done && wb_count != '1)     wb_count   <= wb_count + 1'b1;
      if (fill_done && fill_count != '1) fill_count <= fill_count + 1'b1;
    end
  end
`endif

endmodule
